dds_param_controller: RTL and testbench

Parametrised multi-channel front-panel controller for the DDS datapath. It debounces five raw pushbuttons internally and adds hold-to-repeat on the four step buttons. It maintains saturating frequency, amplitude and waveform registers for `NUM_CH` independent DDS channels, with `ch_sel` choosing the channel being edited. It sits between board I/O and the phase-accumulator/LUT channels, and emits a one-cycle update strobe whenever any channel setting changes.

---
 rtl/dds_param_controller.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dds_param_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_param_controller.sv
// Multi-channel DDS front-panel controller: debounced buttons with hold-to-repeat
// driving saturating per-channel frequency, amplitude and waveform registers.

module dds_btn_cond #(
   parameter int DEBOUNCE_CYC  = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter bit REPEATS       = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press_ev,
   output logic hold_ev
);
   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RC_W = $clog2(RMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LONG} state_t;

   state_t          state, state_n;
   logic            sync1, sync2, deb, deb_d, press;
   logic [DB_W-1:0] db_cnt;
   logic [RC_W-1:0] rcnt, rcnt_n;
   logic            press_n, hold_n;

   assign press = deb & ~deb_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         deb      <= 1'b0;
         deb_d    <= 1'b0;
         db_cnt   <= '0;
         state    <= S_IDLE;
         rcnt     <= '0;
         press_ev <= 1'b0;
         hold_ev  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         if (sync2 == deb) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            deb    <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
         state    <= state_n;
         rcnt     <= rcnt_n;
         press_ev <= press_n;
         hold_ev  <= hold_n;
      end
   end

   // Center uses the DELAY expiry as a one-shot long-press instead of repeating.
   always_comb begin
      state_n = state;
      rcnt_n  = rcnt;
      press_n = 1'b0;
      hold_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (press) begin
               press_n = 1'b1;
               state_n = S_DELAY;
               rcnt_n  = '0;
            end
         end
         S_DELAY: begin
            if (!deb) begin
               state_n = S_IDLE;
            end else if (REPEAT_DELAY != 0) begin
               if (rcnt == RC_W'(REPEAT_DELAY - 1)) begin
                  hold_n  = 1'b1;
                  state_n = REPEATS ? S_REPEAT : S_LONG;
                  rcnt_n  = '0;
               end else begin
                  rcnt_n = rcnt + RC_W'(1);
               end
            end
         end
         S_REPEAT: begin
            if (!deb) begin
               state_n = S_IDLE;
            end else if (rcnt == RC_W'(REPEAT_PERIOD - 1)) begin
               hold_n = 1'b1;
               rcnt_n = '0;
            end else begin
               rcnt_n = rcnt + RC_W'(1);
            end
         end
         default: begin
            if (!deb) state_n = S_IDLE;
         end
      endcase
   end
endmodule

module dds_param_controller #(
   parameter int NUM_CH        = 2,
   parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int FREQ_W        = 16,
   parameter int AMP_W         = 8,
   parameter int FREQ_STEP     = 1000,
   parameter int FREQ_MIN      = 1000,
   parameter int FREQ_MAX      = 20000,
   parameter int FREQ_DEF      = 10000,
   parameter int AMP_STEP      = 3,
   parameter int AMP_MIN       = 3,
   parameter int AMP_MAX       = 99,
   parameter int AMP_DEF       = 30,
   parameter int DEBOUNCE_CYC  = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     btn_up_raw,
   input  logic                     btn_down_raw,
   input  logic                     btn_left_raw,
   input  logic                     btn_right_raw,
   input  logic                     btn_center_raw,
   input  logic [3:0]               sw,
   input  logic [CH_W-1:0]          ch_sel,
   output logic [NUM_CH*FREQ_W-1:0] freq_words,
   output logic [NUM_CH*AMP_W-1:0]  amp_words,
   output logic [NUM_CH*2-1:0]      wave_sels,
   output logic                     update_pulse,
   output logic [CH_W-1:0]          update_ch
);
   localparam logic [FREQ_W-1:0] F_DEF   = FREQ_W'(FREQ_DEF);
   localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0] F_MAX   = FREQ_W'(FREQ_MAX);
   localparam logic [FREQ_W-1:0] F_STEP  = FREQ_W'(FREQ_STEP);
   localparam logic [FREQ_W:0]   F_MAX_X = (FREQ_W+1)'(FREQ_MAX);
   localparam logic [FREQ_W:0]   F_LO_X  = (FREQ_W+1)'(FREQ_MIN + FREQ_STEP);
   localparam logic [FREQ_W:0]   F_STP_X = (FREQ_W+1)'(FREQ_STEP);
   localparam logic [AMP_W-1:0]  A_DEF   = AMP_W'(AMP_DEF);
   localparam logic [AMP_W-1:0]  A_MIN   = AMP_W'(AMP_MIN);
   localparam logic [AMP_W-1:0]  A_MAX   = AMP_W'(AMP_MAX);
   localparam logic [AMP_W-1:0]  A_STEP  = AMP_W'(AMP_STEP);
   localparam logic [AMP_W:0]    A_MAX_X = (AMP_W+1)'(AMP_MAX);
   localparam logic [AMP_W:0]    A_LO_X  = (AMP_W+1)'(AMP_MIN + AMP_STEP);
   localparam logic [AMP_W:0]    A_STP_X = (AMP_W+1)'(AMP_STEP);

   // Button order: 0 up, 1 down, 2 left, 3 right, 4 center.
   logic [4:0] raw_btn, press_ev, hold_ev;
   logic [3:0] step_ev;

   assign raw_btn = {btn_center_raw, btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};
   assign step_ev = press_ev[3:0] | hold_ev[3:0];

   for (genvar i = 0; i < 5; i++) begin : g_btn
      dds_btn_cond #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD),
         .REPEATS      ((i != 4) ? 1'b1 : 1'b0)
      ) u_btn (
         .clock   (clock),
         .reset   (reset),
         .raw     (raw_btn[i]),
         .press_ev(press_ev[i]),
         .hold_ev (hold_ev[i])
      );
   end

   logic [3:0] sw_s1, sw_s2;
   logic [1:0] sw_code, code_q;
   logic       wave_chg;

   always_comb begin
      sw_code = 2'b00;
      if      (sw_s2[3]) sw_code = 2'b00;
      else if (sw_s2[2]) sw_code = 2'b01;
      else if (sw_s2[1]) sw_code = 2'b10;
      else if (sw_s2[0]) sw_code = 2'b11;
   end

   logic [NUM_CH-1:0][FREQ_W-1:0] freq_q, freq_n;
   logic [NUM_CH-1:0][AMP_W-1:0]  amp_q, amp_n;
   logic [NUM_CH-1:0][1:0]        wave_q, wave_n;
   logic [CH_W-1:0]               sel_idx, uch_n;
   logic                          sel_ok, chg;
   logic [FREQ_W:0]               f_sum;
   logic [FREQ_W-1:0]             f_up, f_dn;
   logic [AMP_W:0]                a_sum;
   logic [AMP_W-1:0]              a_up, a_dn;

   assign sel_ok  = int'(ch_sel) < NUM_CH;
   assign sel_idx = sel_ok ? ch_sel : '0;

   // One extra bit on the sums so the upper clamp sees the true value.
   assign f_sum = {1'b0, freq_q[sel_idx]} + F_STP_X;
   assign f_up  = (f_sum > F_MAX_X) ? F_MAX : f_sum[FREQ_W-1:0];
   assign f_dn  = ({1'b0, freq_q[sel_idx]} < F_LO_X) ? F_MIN : freq_q[sel_idx] - F_STEP;
   assign a_sum = {1'b0, amp_q[sel_idx]} + A_STP_X;
   assign a_up  = (a_sum > A_MAX_X) ? A_MAX : a_sum[AMP_W-1:0];
   assign a_dn  = ({1'b0, amp_q[sel_idx]} < A_LO_X) ? A_MIN : amp_q[sel_idx] - A_STEP;

   always_comb begin
      freq_n = freq_q;
      amp_n  = amp_q;
      wave_n = wave_q;
      uch_n  = update_ch;
      if (hold_ev[4]) begin
         freq_n = {NUM_CH{F_DEF}};
         amp_n  = {NUM_CH{A_DEF}};
         wave_n = '0;
         uch_n  = '0;
      end else if (sel_ok) begin
         uch_n = ch_sel;
         if (press_ev[4]) begin
            freq_n[sel_idx] = F_DEF;
            amp_n[sel_idx]  = A_DEF;
            wave_n[sel_idx] = 2'b00;
         end else begin
            if (step_ev[0] && !step_ev[1]) freq_n[sel_idx] = f_up;
            else if (step_ev[1] && !step_ev[0]) freq_n[sel_idx] = f_dn;
            if (step_ev[3] && !step_ev[2]) amp_n[sel_idx] = a_up;
            else if (step_ev[2] && !step_ev[3]) amp_n[sel_idx] = a_dn;
            if (wave_chg) wave_n[sel_idx] = code_q;
         end
      end
   end

   assign chg = (freq_n != freq_q) || (amp_n != amp_q) || (wave_n != wave_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_s1        <= '0;
         sw_s2        <= '0;
         code_q       <= 2'b00;
         wave_chg     <= 1'b0;
         freq_q       <= {NUM_CH{F_DEF}};
         amp_q        <= {NUM_CH{A_DEF}};
         wave_q       <= '0;
         update_pulse <= 1'b0;
         update_ch    <= '0;
      end else begin
         sw_s1        <= sw;
         sw_s2        <= sw_s1;
         code_q       <= sw_code;
         wave_chg     <= (sw_code != code_q);
         freq_q       <= freq_n;
         amp_q        <= amp_n;
         wave_q       <= wave_n;
         update_pulse <= chg;
         if (chg) update_ch <= uch_n;
      end
   end

   assign freq_words = freq_q;
   assign amp_words  = amp_q;
   assign wave_sels  = wave_q;
endmodule

// File: tb/tb_dds_param_controller.sv
// Bench for dds_param_controller: directed scenarios plus random button/switch
// traffic, checked against an event-level model of the channel settings.

module tb_dds_param_controller;
   localparam int DEB = 4, RD = 20, RP = 5, NCH = 2;

   logic        clock = 1'b0, reset = 1'b1;
   logic        up, dn, lf, rt, ct;
   logic [3:0]  sw;
   logic [0:0]  ch_sel;
   logic [31:0] freq_words;
   logic [15:0] amp_words;
   logic [3:0]  wave_sels;
   logic        update_pulse;
   logic [0:0]  update_ch;

   int n_vec = 0, n_err = 0, pulse_total = 0;
   int m_f[NCH], m_a[NCH], m_w[NCH];
   int m_code, m_uch;

   dds_param_controller #(
      .NUM_CH(NCH), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .reset(reset),
      .btn_up_raw(up), .btn_down_raw(dn), .btn_left_raw(lf), .btn_right_raw(rt),
      .btn_center_raw(ct), .sw(sw), .ch_sel(ch_sel),
      .freq_words(freq_words), .amp_words(amp_words), .wave_sels(wave_sels),
      .update_pulse(update_pulse), .update_ch(update_ch)
   );

   always #5 clock = ~clock;
   always @(posedge clock) if (update_pulse) pulse_total++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int enc(input logic [3:0] s);
      if (s[3]) return 0;
      if (s[2]) return 1;
      if (s[1]) return 2;
      if (s[0]) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_f[k] = 10000; m_a[k] = 30; m_w[k] = 0;
      end
      m_code = 0;
      m_uch  = 0;
   endtask

   task automatic check_regs(input string tag);
      for (int k = 0; k < NCH; k++) begin
         chk({tag, "/freq"}, freq_words[k*16 +: 16], m_f[k]);
         chk({tag, "/amp"},  amp_words[k*8 +: 8],    m_a[k]);
         chk({tag, "/wave"}, wave_sels[k*2 +: 2],    m_w[k]);
      end
      chk({tag, "/uch"}, update_ch, m_uch);
   endtask

   // Raw held n sampled cycles: debounced press needs n >= DEB; event offsets t
   // (relative to the press) exist for t < n: press at 0, repeats at RD + k*RP.
   task automatic model_hold(input logic [4:0] m, input int n, input int sel, output int pulses);
      int  of[NCH], oa[NCH], ow[NCH];
      bit  sev, cs, cl, changed;
      pulses = 0;
      if (n < DEB) return;
      for (int t = 0; t < n; t++) begin
         sev = (t == 0) || (t >= RD && (t - RD) % RP == 0);
         cs  = m[4] && (t == 0);
         cl  = m[4] && (t == RD);
         if (!sev) continue;
         of = m_f; oa = m_a; ow = m_w;
         if (cl) begin
            for (int k = 0; k < NCH; k++) begin
               m_f[k] = 10000; m_a[k] = 30; m_w[k] = 0;
            end
         end else if (cs) begin
            m_f[sel] = 10000; m_a[sel] = 30; m_w[sel] = 0;
         end else begin
            if (m[0] && !m[1]) m_f[sel] = (m_f[sel] + 1000 > 20000) ? 20000 : m_f[sel] + 1000;
            else if (m[1] && !m[0]) m_f[sel] = (m_f[sel] - 1000 < 1000) ? 1000 : m_f[sel] - 1000;
            if (m[3] && !m[2]) m_a[sel] = (m_a[sel] + 3 > 99) ? 99 : m_a[sel] + 3;
            else if (m[2] && !m[3]) m_a[sel] = (m_a[sel] - 3 < 3) ? 3 : m_a[sel] - 3;
         end
         changed = 0;
         for (int k = 0; k < NCH; k++)
            if (m_f[k] != of[k] || m_a[k] != oa[k] || m_w[k] != ow[k]) changed = 1;
         if (changed) begin
            pulses++;
            m_uch = cl ? 0 : sel;
         end
      end
   endtask

   task automatic run_hold(input string tag, input logic [4:0] m, input int n, input int sel);
      int p0, ep;
      @(negedge clock);
      ch_sel = 1'(sel);
      p0 = pulse_total;
      {ct, rt, lf, dn, up} = m;
      repeat (n) @(negedge clock);
      {ct, rt, lf, dn, up} = '0;
      repeat (2*DEB + 12) @(negedge clock);
      model_hold(m, n, sel, ep);
      chk({tag, "/pulses"}, pulse_total - p0, ep);
      chk({tag, "/pulse_idle"}, update_pulse, 0);
      check_regs(tag);
   endtask

   task automatic run_wave(input string tag, input logic [3:0] s, input int sel);
      int p0, ep, code;
      @(negedge clock);
      ch_sel = 1'(sel);
      sw = s;
      p0 = pulse_total;
      repeat (8) @(negedge clock);
      code = enc(s);
      ep = 0;
      if (code != m_code) begin
         m_code = code;
         if (m_w[sel] != code) begin
            m_w[sel] = code; m_uch = sel; ep = 1;
         end
      end
      chk({tag, "/pulses"}, pulse_total - p0, ep);
      check_regs(tag);
   endtask

   initial begin
      int p0, ep, kind, sel, n;
      logic [4:0] m;
      {ct, rt, lf, dn, up} = '0;
      sw = '0;
      ch_sel = '0;
      model_reset();
      repeat (3) @(negedge clock);
      check_regs("reset");
      chk("reset/pulse", update_pulse, 0);
      reset = 1'b0;

      // Bounce: 2-cycle chatter never qualifies; stable 1 updates at edge DEB+3.
      @(negedge clock);
      p0 = pulse_total;
      for (int i = 0; i < 20; i++) begin
         up = ((i / 2) % 2 == 0);
         @(negedge clock);
      end
      up = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         if (k == 6) begin
            chk("bounce/early_freq", freq_words[15:0], 10000);
            chk("bounce/early_pulse", update_pulse, 0);
         end
         if (k == 7) begin
            chk("bounce/freq", freq_words[15:0], 11000);
            chk("bounce/pulse", update_pulse, 1);
         end
      end
      @(negedge clock);
      repeat (2) @(negedge clock);
      up = 1'b0;
      repeat (20) @(negedge clock);
      m_f[0] = 11000;
      chk("bounce/pulses", pulse_total - p0, 1);
      check_regs("bounce");

      run_hold("deb_short", 5'b00001, DEB - 1, 0);
      run_hold("deb_exact", 5'b00001, DEB, 0);
      chk("deb_exact/freq", freq_words[15:0], 12000);

      run_hold("arep", 5'b01000, 44, 0);
      chk("arep/amp", amp_words[7:0], 48);

      for (int i = 0; i < 12; i++) run_hold("sat_up", 5'b00001, 6, 1);
      chk("sat_up/freq", freq_words[31:16], 20000);
      for (int i = 0; i < 12; i++) run_hold("sat_left", 5'b00100, 6, 1);
      chk("sat_left/amp", amp_words[15:8], 3);

      run_hold("updn", 5'b00011, 6, 0);
      run_hold("ctr_up", 5'b10001, 6, 1);
      chk("ctr_up/freq", freq_words[31:16], 10000);
      chk("ctr_up/amp", amp_words[15:8], 30);

      run_hold("pre_long", 5'b00001, 6, 1);
      run_hold("long", 5'b10000, 25, 1);
      chk("long/uch", update_ch, 0);
      chk("long/freqs", freq_words, {16'd10000, 16'd10000});

      // Waveform: write lands on exactly the fourth edge after the change.
      @(negedge clock);
      ch_sel = 1'b1;
      sw = 4'b0100;
      repeat (3) @(posedge clock);
      #1 chk("wave/early", wave_sels, 4'b0000);
      @(posedge clock);
      #1 chk("wave/lat", wave_sels, 4'b0100);
      chk("wave/pulse", update_pulse, 1);
      m_code = 1; m_w[1] = 1; m_uch = 1;
      repeat (6) @(negedge clock);
      check_regs("wave");
      run_wave("sel_only", 4'b0100, 0);
      run_wave("sw_zero", 4'b0000, 0);

      // Reset mid-hold, then the still-held button re-debounces.
      @(negedge clock);
      ch_sel = 1'b0;
      up = 1'b1;
      repeat (12) @(negedge clock);
      chk("rst/pre_freq", freq_words[15:0], 11000);
      reset = 1'b1;
      #1 model_reset();
      check_regs("rst");
      chk("rst/pulse", update_pulse, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      p0 = pulse_total;
      repeat (10) @(negedge clock);
      up = 1'b0;
      repeat (20) @(negedge clock);
      model_hold(5'b00001, 10, 0, ep);
      chk("rst/pulses", pulse_total - p0, ep);
      check_regs("rst_after");
      chk("rst/freq", freq_words[15:0], 11000);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         sel  = $urandom_range(0, 1);
         if (kind < 2) begin
            run_wave("rnd_sw", 4'($urandom_range(0, 15)), sel);
         end else begin
            m = 5'(1) << $urandom_range(0, 4);
            if (kind == 9) m = m | (5'(1) << $urandom_range(0, 4));
            n = $urandom_range(1, 50);
            run_hold("rnd_btn", m, n, sel);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
